// File: rtl/peripheral_uart_fifo.sv
`default_nettype none
// ============================================================================
// peripheral_uart_fifo : 8N1 UART with TX/RX FIFOs, baud divisor, sticky errors, irq
// Revision 1.0
// ============================================================================
module peripheral_uart_fifo #(
  parameter int          TX_DEPTH  = 16,
  parameter int          RX_DEPTH  = 16,
  parameter logic [15:0] DIV_RESET = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        ledout,
  output logic        irq
);
  localparam int TXW = $clog2(TX_DEPTH);
  localparam int RXW = $clog2(RX_DEPTH);
  localparam logic [3:0] A_STATUS = 4'h0;
  localparam logic [3:0] A_TXDATA = 4'h2;
  localparam logic [3:0] A_LED    = 4'h4;
  localparam logic [3:0] A_RXDATA = 4'h6;
  localparam logic [3:0] A_BAUD   = 4'h8;
  localparam logic [3:0] A_CTRL   = 4'hA;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic        wr_en, rd_en, clr_sticky;
  logic [15:0] baud_q, dout_q, rdata;
  logic [1:0]  ctrl_q;
  logic        led_q, irq_q, irq_d, ovr_q, ferr_q, drop_q;

  logic [7:0]   tx_mem [TX_DEPTH];
  logic [TXW:0] tx_wp_q, tx_rp_q;
  logic         tx_full, tx_empty, tx_push, tx_pop, tx_active;
  logic [7:0]   rx_mem [RX_DEPTH];
  logic [RXW:0] rx_wp_q, rx_rp_q;
  logic         rx_full, rx_empty, rx_push, rx_pop, rx_push_req, ferr_set;

  state_t      tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d, rx_half, rx_start_ld;
  logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic        txo_q, txo_d, rx_s1_q, rx_s2_q, rx_prev_q;

  assign wr_en      = cs & wr;
  assign rd_en      = cs & rd;
  assign clr_sticky = wr_en && (addr == A_CTRL) && d_in[2];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign tx_empty  = (tx_wp_q == tx_rp_q);
  assign tx_full   = (tx_wp_q[TXW] != tx_rp_q[TXW]) && (tx_wp_q[TXW-1:0] == tx_rp_q[TXW-1:0]);
  assign rx_empty  = (rx_wp_q == rx_rp_q);
  assign rx_full   = (rx_wp_q[RXW] != rx_rp_q[RXW]) && (rx_wp_q[RXW-1:0] == rx_rp_q[RXW-1:0]);
  assign tx_push   = wr_en && (addr == A_TXDATA) && !tx_full;
  assign rx_pop    = rd_en && (addr == A_RXDATA) && !rx_empty;
  assign rx_push   = rx_push_req && !rx_full;
  assign tx_active = (tx_st_q != S_IDLE);

  assign rx_half     = {1'b0, baud_q[15:1]} + {15'd0, baud_q[0]};
  assign rx_start_ld = (rx_half == 16'd0) ? 16'd0 : rx_half - 16'd1;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q[TXW-1:0]] <= d_in[7:0];
    if (rx_push) rx_mem[rx_wp_q[RXW-1:0]] <= rx_sh_q;
  end

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    txo_d    = txo_q;
    tx_pop   = 1'b0;
    case (tx_st_q)
      S_IDLE:  tx_pop = !tx_empty;
      S_START: begin
        if (tx_cnt_q == 16'd0) begin
          tx_st_d  = S_DATA;
          tx_bit_d = 3'd0;
          txo_d    = tx_sh_q[0];
          tx_cnt_d = baud_q;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      S_DATA: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = baud_q;
          if (tx_bit_q == 3'd7) begin
            tx_st_d = S_STOP;
            txo_d   = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            txo_d    = tx_sh_q[tx_bit_q + 3'd1];
          end
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      S_STOP: begin
        if (tx_cnt_q == 16'd0) begin
          if (tx_empty) tx_st_d = S_IDLE;
          else          tx_pop  = 1'b1;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      default: tx_st_d = S_IDLE;
    endcase
    // Loading the next byte straight from STOP keeps back-to-back frames gapless.
    if (tx_pop) begin
      tx_sh_d  = tx_mem[tx_rp_q[TXW-1:0]];
      tx_st_d  = S_START;
      tx_cnt_d = baud_q;
      txo_d    = 1'b0;
    end
  end

  always_comb begin
    rx_st_d     = rx_st_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_push_req = 1'b0;
    ferr_set    = 1'b0;
    case (rx_st_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_st_d  = S_START;
          rx_cnt_d = rx_start_ld;
        end
      end
      S_START: begin
        if (rx_cnt_q == 16'd0) begin
          rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
          rx_bit_d = 3'd0;
          rx_cnt_d = baud_q;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      S_DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_cnt_d = baud_q;
          if (rx_bit_q == 3'd7) rx_st_d  = S_STOP;
          else                  rx_bit_d = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      S_STOP: begin
        if (rx_cnt_q == 16'd0) begin
          rx_st_d     = S_IDLE;
          rx_push_req = rx_s2_q;
          ferr_set    = !rx_s2_q;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      default: rx_st_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata = 16'h0000;
    case (addr)
      A_STATUS: rdata = {8'h00, drop_q, ferr_q, tx_active, ovr_q, rx_full, !rx_empty, tx_empty, tx_full};
      A_RXDATA: if (!rx_empty) rdata = {8'h00, rx_mem[rx_rp_q[RXW-1:0]]};
      A_BAUD:   rdata = baud_q;
      A_CTRL:   rdata = {14'h0000, ctrl_q};
      default:  rdata = 16'h0000;
    endcase
  end

  assign irq_d = (ctrl_q[0] & (!rx_empty | ovr_q | ferr_q)) | (ctrl_q[1] & tx_empty & !tx_active);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_q    <= DIV_RESET;
      ctrl_q    <= 2'b00;
      led_q     <= 1'b0;
      dout_q    <= 16'h0000;
      irq_q     <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      drop_q    <= 1'b0;
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      tx_st_q   <= S_IDLE;
      tx_cnt_q  <= 16'd0;
      tx_bit_q  <= 3'd0;
      tx_sh_q   <= 8'h00;
      txo_q     <= 1'b1;
      rx_st_q   <= S_IDLE;
      rx_cnt_q  <= 16'd0;
      rx_bit_q  <= 3'd0;
      rx_sh_q   <= 8'h00;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      if (wr_en && addr == A_LED)  led_q  <= d_in[0];
      if (wr_en && addr == A_BAUD) baud_q <= d_in;
      if (wr_en && addr == A_CTRL) ctrl_q <= d_in[1:0];
      if (rd_en) dout_q <= rdata;
      irq_q     <= irq_d;
      drop_q    <= (drop_q & !clr_sticky) | (wr_en && addr == A_TXDATA && tx_full);
      ovr_q     <= (ovr_q & !clr_sticky) | (rx_push_req & rx_full);
      ferr_q    <= (ferr_q & !clr_sticky) | ferr_set;
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
      tx_st_q   <= tx_st_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      txo_q     <= txo_d;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign d_out   = dout_q;
  assign uart_tx = txo_q;
  assign ledout  = led_q;
  assign irq     = irq_q;
endmodule
`default_nettype wire

// File: tb/tb_peripheral_uart_fifo.sv
`default_nettype none
// ============================================================================
// tb_peripheral_uart_fifo : randomized scoreboard bench for peripheral_uart_fifo
// Revision 1.0
// ============================================================================
module tb_peripheral_uart_fifo;
  localparam int TXD = 4;
  localparam int RXD = 4;
  localparam logic [15:0] DIVR = 16'd433;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] d_in = 16'h0;
  logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [15:0] d_out;
  logic        uart_tx, uart_rx, ledout, irq;
  logic        loop_en = 1'b0, rx_drv = 1'b1;

  assign uart_rx = loop_en ? uart_tx : rx_drv;

  peripheral_uart_fifo #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .DIV_RESET(DIVR)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
    .d_out(d_out), .uart_tx(uart_tx), .uart_rx(uart_rx), .ledout(ledout), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] val; string name; } rd_exp_t;
  rd_exp_t    rdq[$];
  rd_exp_t    mon_x;
  logic [7:0] exp_tx[$];
  logic [7:0] m_rx[$];
  int         gaps[$];
  bit         m_ovr = 0, m_ferr = 0, m_drop = 0;
  int         cur_baud = DIVR;
  int         checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Expected STATUS when the transmitter is idle, derived from the model.
  function automatic logic [15:0] status_idle();
    return {8'h00, m_drop, m_ferr, 1'b0, m_ovr, (m_rx.size() == RXD), (m_rx.size() != 0), 1'b1, 1'b0};
  endfunction

  task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk); cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
    @(negedge clk); cs = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [3:0] a, input logic [15:0] e, input string nm);
    rd_exp_t x;
    x.val = e; x.name = nm;
    @(negedge clk); rdq.push_back(x); cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk); cs = 1'b0; rd = 1'b0;
  endtask

  task automatic set_baud(input int b);
    wr_reg(4'h8, b[15:0]);
    cur_baud = b;
  endtask

  task automatic clear_sticky();
    wr_reg(4'hA, 16'h0004);
    m_ovr = 0; m_ferr = 0; m_drop = 0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb);
    int p;
    p = cur_baud + 1;
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (p) @(negedge clk);
    end
    rx_drv = stopb;
    repeat (p) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  task automatic wait_tx_drain(input int budget, input string nm);
    int n;
    n = 0;
    while (exp_tx.size() != 0 && n < budget) begin
      @(negedge clk); n++;
    end
    chk(nm, exp_tx.size(), 0);
  endtask

  // Read monitor: response appears on d_out one edge after the rd cycle.
  always @(posedge clk) begin
    if (cs && rd && !rst) begin
      if (rdq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_read: got a read with no expectation queued, expected none");
      end else begin
        mon_x = rdq.pop_front();
        #1;
        chk(mon_x.name, d_out, mon_x.val);
      end
    end
  end

  task automatic mon_run(input int n, input logic lvl, inout bit good, inout bit ab);
    for (int i = 0; i < n && !ab; i++) begin
      @(negedge clk);
      if (rst) ab = 1;
      else if (uart_tx !== lvl) good = 0;
    end
  endtask

  // Serial monitor: checks each frame's exact bit timing and content.
  initial begin : tx_mon
    int idle, p;
    bit good, ab;
    logic [7:0] data, e;
    idle = 0;
    forever begin
      @(negedge clk);
      if (rst) idle = 0;
      else if (uart_tx !== 1'b0) idle++;
      else begin
        p = cur_baud + 1;
        gaps.push_back(idle);
        idle = 0; good = 1; ab = 0; data = 8'h00;
        mon_run(p - 1, 1'b0, good, ab);
        for (int b = 0; b < 8 && !ab; b++) begin
          @(negedge clk);
          if (rst) ab = 1;
          else begin
            data[b] = uart_tx;
            mon_run(p - 1, uart_tx, good, ab);
          end
        end
        if (!ab) mon_run(p, 1'b1, good, ab);
        if (!ab) begin
          if (!good) begin
            checks++; errors++;
            $display("FAIL tx_frame_shape: got malformed frame (bits 0x%0h), expected clean 8N1 frame of %0d clk/bit", data, p);
          end else if (exp_tx.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_extra_frame: got frame 0x%0h, expected no frame", data);
          end else begin
            e = exp_tx.pop_front();
            chk("tx_frame_data", data, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: got no completion within time limit, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] b;
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_d_out", d_out, 16'h0);
    chk("reset_uart_tx", uart_tx, 1'b1);
    chk("reset_ledout", ledout, 1'b0);
    chk("reset_irq", irq, 1'b0);
    rd_reg(4'h0, 16'h0002, "reset_status");
    rd_reg(4'h8, DIVR, "reset_baud");
    rd_reg(4'hA, 16'h0000, "reset_ctrl");

    // Single frame at BAUD=3, exact waveform checked by the serial monitor.
    set_baud(3);
    rd_reg(4'h8, 16'd3, "baud_readback");
    exp_tx.push_back(8'h55);
    wr_reg(4'h2, 16'h0055);
    wait_tx_drain(200, "tx_0x55_drain");
    rd_reg(4'h0, status_idle(), "status_after_tx");
    wr_reg(4'hA, 16'h0002);
    rd_reg(4'hA, 16'h0002, "ctrl_readback");
    repeat (3) @(negedge clk);
    chk("irq_tx_empty", irq, 1'b1);
    wr_reg(4'hA, 16'h0000);
    repeat (3) @(negedge clk);
    chk("irq_cleared", irq, 1'b0);

    // Loopback, back-to-back frames.
    set_baud(7);
    loop_en = 1'b1;
    gaps.delete();
    foreach (exp_tx[i]) ;
    for (int i = 0; i < 3; i++) begin
      b = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'hA5;
      exp_tx.push_back(b);
      m_rx.push_back(b);
      wr_reg(4'h2, {8'h00, b});
    end
    wait_tx_drain(600, "loopback_drain");
    repeat (20) @(negedge clk);
    chk("gap_frame2", (gaps.size() > 1) ? gaps[1] : -1, 0);
    chk("gap_frame3", (gaps.size() > 2) ? gaps[2] : -1, 0);
    rd_reg(4'h0, status_idle(), "loop_status");
    for (int i = 0; i < 3; i++) rd_reg(4'h6, {8'h00, m_rx.pop_front()}, "loop_rxdata");
    rd_reg(4'h6, 16'h0000, "rxdata_empty");
    rd_reg(4'h0, status_idle(), "loop_status_empty");
    loop_en = 1'b0;

    // TX overflow with a slow divisor.
    set_baud(100);
    for (int i = 0; i < TXD + 2; i++) begin
      b = $urandom_range(0, 255);
      if (i < TXD + 1) exp_tx.push_back(b);
      else m_drop = 1;
      wr_reg(4'h2, {8'h00, b});
    end
    rd_reg(4'h0, {8'h00, 8'hA1}, "tx_full_drop_status");
    wr_reg(4'hA, 16'h0004);
    m_drop = 0;
    rd_reg(4'h0, {8'h00, 8'h21}, "tx_drop_cleared");
    wait_tx_drain((TXD + 2) * 10 * 101 + 200, "tx_overflow_drain");
    repeat (300) @(negedge clk);
    rd_reg(4'h0, status_idle(), "tx_overflow_idle");

    // RX overflow with random bytes.
    set_baud(7);
    clear_sticky();
    for (int i = 0; i < RXD + 1; i++) begin
      b = $urandom_range(0, 255);
      if (m_rx.size() < RXD) m_rx.push_back(b);
      else m_ovr = 1;
      send_rx(b, 1'b1);
    end
    repeat (10) @(negedge clk);
    rd_reg(4'h0, status_idle(), "rx_full_overrun_status");
    n = m_rx.size();
    for (int i = 0; i < n; i++) rd_reg(4'h6, {8'h00, m_rx.pop_front()}, "rx_overflow_data");
    rd_reg(4'h0, status_idle(), "rx_drained_status");

    // Glitch rejection and framing error.
    clear_sticky();
    @(negedge clk); rx_drv = 1'b0;
    @(negedge clk); rx_drv = 1'b1;
    repeat (120) @(negedge clk);
    rd_reg(4'h0, status_idle(), "glitch_rejected");
    send_rx(8'h3C, 1'b0);
    m_ferr = 1;
    repeat (20) @(negedge clk);
    rd_reg(4'h0, status_idle(), "frame_err_status");
    chk("irq_masked", irq, 1'b0);
    @(negedge clk); rx_drv = 1'b0;
    @(negedge clk); rx_drv = 1'b1;
    repeat (120) @(negedge clk);
    rd_reg(4'h0, status_idle(), "glitch_after_ferr");
    wr_reg(4'hA, 16'h0001);
    repeat (3) @(negedge clk);
    chk("irq_rx_ferr", irq, 1'b1);

    // Reset in the middle of a transmitted frame.
    wr_reg(4'h4, 16'h0001);
    @(negedge clk);
    chk("ledout_set", ledout, 1'b1);
    exp_tx.push_back(8'h00);
    wr_reg(4'h2, 16'h0000);
    n = 0;
    while (uart_tx !== 1'b0 && n < 200) begin
      @(negedge clk); n++;
    end
    chk("mid_frame_start_seen", n < 200, 1'b1);
    repeat (4 * 8 + 4) @(negedge clk);
    chk("tx_low_in_bit3", uart_tx, 1'b0);
    rst = 1'b1;
    #1;
    chk("async_reset_tx_high", uart_tx, 1'b1);
    exp_tx.delete();
    m_rx.delete();
    m_ovr = 0; m_ferr = 0; m_drop = 0;
    cur_baud = DIVR;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_d_out", d_out, 16'h0);
    chk("post_reset_ledout", ledout, 1'b0);
    chk("post_reset_irq", irq, 1'b0);
    rd_reg(4'h0, 16'h0002, "post_reset_status");
    rd_reg(4'h8, DIVR, "post_reset_baud");
    repeat (5) @(negedge clk);
    chk("read_queue_empty", rdq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
